// File: rtl/seg7_scan_driver_pkg.sv
// Shared constants for the four-digit seven-segment scan driver.
// Glyphs are active-high with segment a on bit 0 through segment g on bit 6.
package seg7_scan_driver_pkg;

    localparam int NUM_DIGITS = 4;

    localparam logic [6:0] SEG_OFF = 7'h00;
    localparam logic [6:0] SEG_0   = 7'h3F;
    localparam logic [6:0] SEG_1   = 7'h06;
    localparam logic [6:0] SEG_2   = 7'h5B;
    localparam logic [6:0] SEG_3   = 7'h4F;
    localparam logic [6:0] SEG_4   = 7'h66;
    localparam logic [6:0] SEG_5   = 7'h6D;
    localparam logic [6:0] SEG_6   = 7'h7D;
    localparam logic [6:0] SEG_7   = 7'h07;
    localparam logic [6:0] SEG_8   = 7'h7F;
    localparam logic [6:0] SEG_9   = 7'h6F;
    localparam logic [6:0] SEG_A   = 7'h77;
    localparam logic [6:0] SEG_B   = 7'h7C;
    localparam logic [6:0] SEG_C   = 7'h39;
    localparam logic [6:0] SEG_D   = 7'h5E;
    localparam logic [6:0] SEG_E   = 7'h79;
    localparam logic [6:0] SEG_F   = 7'h71;

    // What the active slot is doing on the next registered output update.
    typedef enum logic [1:0] {
        PH_BLANK = 2'd0,
        PH_LIT   = 2'd1,
        PH_DARK  = 2'd2
    } phase_e;

endpackage

// File: rtl/seg7_scan_driver_hex_to_seg7.sv
// Combinational hex nibble to seven-segment glyph decoder (b and d lowercase).
module hex_to_seg7
    import seg7_scan_driver_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_OFF;
        case (nibble)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            4'hF: seg = SEG_F;
            default: seg = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Four-digit multiplexed seven-segment driver with blanking, frame-aligned
// double buffering and optional leading-zero suppression.
module seg7_scan_driver
    import seg7_scan_driver_pkg::*;
#(
    parameter int CLK_DIV      = 12500,
    parameter int BLANK_CYCLES = 250
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] value,
    input  logic        load,
    input  logic [3:0]  dp_in,
    input  logic        blank_lz,
    output logic [6:0]  seg,
    output logic        dp_out,
    output logic [3:0]  digit_en,
    output logic        frame_done
);

    localparam int CW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int IDX_W = $clog2(NUM_DIGITS);

    logic [CW-1:0]    slot_cnt;
    logic [IDX_W-1:0] dig_idx;
    logic [15:0]      pend_val;
    logic [3:0]       pend_dp;
    logic             pending_valid;
    logic [15:0]      shadow_val;
    logic [3:0]       shadow_dp;

    logic             slot_wrap;
    logic             frame_edge;
    logic [15:0]      upper_nibbles;
    logic [6:0]       cur_seg;
    phase_e           phase;
    logic [6:0]       seg_d;
    logic             dp_d;
    logic [3:0]       en_d;

    assign slot_wrap  = (slot_cnt == CW'(CLK_DIV - 1));
    assign frame_edge = slot_wrap && (dig_idx == IDX_W'(NUM_DIGITS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_cnt <= '0;
            dig_idx  <= '0;
        end else if (slot_wrap) begin
            slot_cnt <= '0;
            dig_idx  <= dig_idx + 1'b1;
        end else begin
            slot_cnt <= slot_cnt + 1'b1;
        end
    end

    // load is a fire-and-forget strobe with no ready: every cycle it is high
    // is accepted, the last one before a frame boundary is the one displayed,
    // and a load on the boundary edge itself goes straight to the shadow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_val      <= '0;
            pend_dp       <= '0;
            pending_valid <= 1'b0;
            shadow_val    <= '0;
            shadow_dp     <= '0;
        end else if (frame_edge) begin
            pending_valid <= 1'b0;
            if (load) begin
                shadow_val <= value;
                shadow_dp  <= dp_in;
            end else if (pending_valid) begin
                shadow_val <= pend_val;
                shadow_dp  <= pend_dp;
            end
        end else if (load) begin
            pend_val      <= value;
            pend_dp       <= dp_in;
            pending_valid <= 1'b1;
        end
    end

    // Nibbles from the active digit upward; all zero means a leading zero.
    assign upper_nibbles = shadow_val >> {dig_idx, 2'b00};

    hex_to_seg7 u_hex_to_seg7 (
        .nibble (upper_nibbles[3:0]),
        .seg    (cur_seg)
    );

    always_comb begin
        phase = PH_LIT;
        if (slot_cnt < CW'(BLANK_CYCLES)) begin
            phase = PH_BLANK;
        end else if (blank_lz && (dig_idx != '0) && (upper_nibbles == 16'h0)) begin
            phase = PH_DARK;
        end
    end

    always_comb begin
        seg_d = SEG_OFF;
        dp_d  = 1'b0;
        en_d  = 4'b0000;
        if (phase == PH_LIT) begin
            seg_d = cur_seg;
            dp_d  = shadow_dp[dig_idx];
            en_d  = 4'b0001 << dig_idx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg        <= SEG_OFF;
            dp_out     <= 1'b0;
            digit_en   <= 4'b0000;
            frame_done <= 1'b0;
        end else begin
            seg        <= seg_d;
            dp_out     <= dp_d;
            digit_en   <= en_d;
            frame_done <= frame_edge;
        end
    end

endmodule
